// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, digit count, reader FSM states and pattern decode
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        return p == SEG_0 ? 5'h10 : p == SEG_1 ? 5'h11 : p == SEG_2 ? 5'h12 :
               p == SEG_3 ? 5'h13 : p == SEG_4 ? 5'h14 : p == SEG_5 ? 5'h15 :
               p == SEG_6 ? 5'h16 : p == SEG_7 ? 5'h17 : p == SEG_8 ? 5'h18 :
               p == SEG_9 ? 5'h19 : 5'h00;
    endfunction
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: normalized 7-segment pattern to {legal, BCD digit}
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] bcd
);
    assign {legal, bcd} = seg_decode(seg);
endmodule

// File: rtl/seg7_4digit_reader.sv
// seg7_4digit_reader: debounced 4-digit 7-segment reader with BCD-to-binary conversion.
// Define SEG7_READER_ERRCNT_EN to add the saturating ERR_CNT output.
module seg7_4digit_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LED_type_ctl,
    input  logic [6:0]  LED1,
    input  logic [6:0]  LED2,
    input  logic [6:0]  LED3,
    input  logic [6:0]  LED4,
    output logic [15:0] BCD,
    output logic [13:0] BIN,
    output logic        VALID,
    output logic        ERR,
    output logic        BUSY
`ifdef SEG7_READER_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15 || ERR_CNT_W < 1) begin : g_bad_cfg
        $error("seg7_4digit_reader: STABLE_CYCLES must be 1..15 and ERR_CNT_W >= 1");
    end

    logic [27:0] raw, smp, smp_nxt, hold, hold_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] legal;
    logic [1:0]  step;
    logic [13:0] acc, acc_nxt;
    logic        seen, seen_nxt, accepted, accept, word_legal;
    state_t      state, state_nxt;

    assign raw      = {LED4, LED3, LED2, LED1} ^ {28{LED_type_ctl}};
    assign smp_nxt  = EN ? raw : smp;
    // the reset value of S is not a real sample, so it never counts as a match
    assign cnt_nxt  = !EN ? cnt : (!seen || raw != smp) ? 4'd0 :
                      cnt == 4'(STABLE_CYCLES) ? cnt : cnt + 4'd1;
    assign seen_nxt = seen | EN;
    assign accept   = state == IDLE && seen_nxt && cnt_nxt >= 4'(STABLE_CYCLES - 1) &&
                      (!accepted || smp_nxt != hold);
    assign hold_nxt = accept ? smp_nxt : hold;
    assign word_legal = &legal;
    assign acc_nxt  = (acc << 3) + (acc << 1) + {10'd0, dig[3 - step]};
    assign BUSY     = state != IDLE;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_digit_decode u_dec (
            .seg   (hold_nxt[7*i +: 7]),
            .legal (legal[i]),
            .bcd   (dig[i])
        );
    end

    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == IDLE ? ((accept && word_legal) ? CONV : IDLE) :
                    state == CONV ? (step == 2'd3 ? DONE : CONV) : IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp      <= '0;
            cnt      <= '0;
            seen     <= 1'b0;
            hold     <= '0;
            accepted <= 1'b0;
            state    <= IDLE;
            step     <= '0;
            acc      <= '0;
            BIN      <= '0;
            BCD      <= '0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            smp      <= smp_nxt;
            cnt      <= cnt_nxt;
            seen     <= seen_nxt;
            hold     <= hold_nxt;
            accepted <= accepted | accept;
            state    <= state_nxt;
            step     <= state == CONV ? step + 2'd1 : 2'd0;
            acc      <= state == CONV ? acc_nxt : 14'd0;
            VALID    <= state == CONV && step == 2'd3;
            ERR      <= accept && !word_legal;
            if (state == CONV && step == 2'd3) begin
                BIN <= acc_nxt;
                BCD <= {dig[3], dig[2], dig[1], dig[0]};
            end
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ERR_CNT <= '0;
        else if (ERR && !(&ERR_CNT))
            ERR_CNT <= ERR_CNT + 1'b1;
    end
`endif
endmodule

// File: tb/tb_seg7_4digit_reader.sv
// tb_seg7_4digit_reader: table-driven and sequence checks for seg7_4digit_reader (STABLE_CYCLES=2)
module tb_seg7_4digit_reader;
    logic        CLK = 1'b0, RST = 1'b1, EN = 1'b1, LED_type_ctl = 1'b0;
    logic [6:0]  LED1 = '0, LED2 = '0, LED3 = '0, LED4 = '0;
    logic [15:0] BCD;
    logic [13:0] BIN;
    logic        VALID, ERR, BUSY;
`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0]  ERR_CNT;
`endif

    int n_cmp = 0, n_fail = 0;
    int n_valid = 0, n_err = 0;

    seg7_4digit_reader #(.STABLE_CYCLES(2), .ERR_CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LED_type_ctl(LED_type_ctl),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4),
        .BCD(BCD), .BIN(BIN), .VALID(VALID), .ERR(ERR), .BUSY(BUSY)
`ifdef SEG7_READER_ERRCNT_EN
        , .ERR_CNT(ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (VALID) n_valid <= n_valid + 1;
        if (ERR) n_err <= n_err + 1;
    end

    typedef struct {
        logic        ctl;
        logic [15:0] dig;
        int          exp_bin;
        int          exp_bcd;
        int          exp_v;
        int          exp_e;
    } vec_t;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            4'd14: return 7'b1001001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic drive(input logic ctl, input logic [15:0] w);
        LED_type_ctl = ctl;
        LED1 = seg(w[3:0]) ^ {7{ctl}};
        LED2 = seg(w[7:4]) ^ {7{ctl}};
        LED3 = seg(w[11:8]) ^ {7{ctl}};
        LED4 = seg(w[15:12]) ^ {7{ctl}};
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        vec_t tbl [6];
        int v0, e0, first;
        tbl[0] = '{1'b0, 16'h0000, 0,    16'h0000, 1, 0};
        tbl[1] = '{1'b0, 16'h1234, 1234, 16'h1234, 1, 0};
        tbl[2] = '{1'b1, 16'h9999, 9999, 16'h9999, 1, 0};
        tbl[3] = '{1'b0, 16'h57F8, 9999, 16'h9999, 0, 1};
        tbl[4] = '{1'b0, 16'h8071, 8071, 16'h8071, 1, 0};
        tbl[5] = '{1'b1, 16'h3EF2, 8071, 16'h8071, 0, 1};

        tick(2);
        check("reset BIN", int'(BIN), 0);
        check("reset BCD", int'(BCD), 0);
        check("reset VALID/ERR/BUSY", int'({VALID, ERR, BUSY}), 0);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].ctl, tbl[i].dig);
            v0 = n_valid;
            e0 = n_err;
            tick(12);
            check($sformatf("vec%0d VALID pulses", i), n_valid - v0, tbl[i].exp_v);
            check($sformatf("vec%0d ERR pulses", i), n_err - e0, tbl[i].exp_e);
            check($sformatf("vec%0d BIN", i), int'(BIN), tbl[i].exp_bin);
            check($sformatf("vec%0d BCD", i), int'(BCD), tbl[i].exp_bcd);
        end
`ifdef SEG7_READER_ERRCNT_EN
        check("ERR_CNT after two bad words", int'(ERR_CNT), 2);
`endif

        v0 = n_valid;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, i[0] ? 16'h6666 : 16'h5555);
            tick(1);
        end
        check("toggle no VALID", n_valid - v0, 0);
        drive(1'b0, 16'h6666);
        tick(12);
        check("toggle then hold VALID", n_valid - v0, 1);
        check("toggle then hold BIN", int'(BIN), 6666);

        v0 = n_valid;
        EN = 1'b0;
        drive(1'b0, 16'h7777);
        tick(8);
        check("EN low no VALID", n_valid - v0, 0);
        check("EN low BIN held", int'(BIN), 6666);
        EN = 1'b1;
        tick(12);
        check("EN high BIN", int'(BIN), 7777);

        v0 = n_valid;
        drive(1'b0, 16'h4321);
        tick(1);
        check("BUSY before accept", int'(BUSY), 0);
        tick(1);
        check("BUSY after accept", int'(BUSY), 1);
        tick(2);
        RST = 1'b1;
        #1;
        check("mid-reset BIN", int'(BIN), 0);
        check("mid-reset BCD", int'(BCD), 0);
        check("mid-reset VALID/ERR/BUSY", int'({VALID, ERR, BUSY}), 0);
        tick(3);
        check("mid-reset no VALID", n_valid - v0, 0);
        RST = 1'b0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (VALID && first == 0) first = i;
        end
        check("latency edges to VALID", first, 6);
        check("after reset VALID pulses", n_valid - v0, 1);
        check("after reset BIN", int'(BIN), 4321);
        check("after reset BCD", int'(BCD), 16'h4321);
        check("after reset BUSY idle", int'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_4digit_reader.md
# seg7_4digit_reader

Hardware reader for the 4-digit 7-segment bus driven by the BCD counter's `LED1`..`LED4` outputs.
- Samples the segment patterns and waits until they are stable for a programmable number of cycles.
- Decodes each digit to BCD, flagging illegal patterns.
- Runs a sequential BCD-to-binary conversion and reports the displayed value with a one-cycle `VALID` strobe.
- Sits on the display side of the counter; used for self-check and for feeding the count back into logic.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical enabled samples required before a word is accepted; legal range 1..15.
- `ERR_CNT_W`, default 8: width of the error counter; used only with the macro.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  sample enable.
- `LED_type_ctl`  in  1  segment polarity.
  - 0: active-high segments.
  - 1: active-low segments; inputs are inverted before decode.
- `LED1`  in  7  least-significant digit, bit6=a .. bit0=g.
- `LED2`, `LED3`  in  7 each  middle digits.
- `LED4`  in  7  most-significant digit.
- `BCD`  out  16  {d3,d2,d1,d0} of the last valid word.
- `BIN`  out  14  binary value of the last valid word, 0..9999.
- `VALID`  out  1  one-cycle strobe: `BCD`/`BIN` updated.
- `ERR`  out  1  one-cycle strobe: accepted word contains an illegal digit.
- `BUSY`  out  1  conversion in progress.
- `ERR_CNT`  out  `ERR_CNT_W`  present only with `SEG7_READER_ERRCNT_EN`.

## Operation
- **Normalization:** `n = LED_type_ctl ? ~LEDx : LEDx`.
- **Legal patterns:** 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Everything else, including blank 0000000, is illegal.
- **Sampling:** on each edge with `EN`=1, the 28-bit normalized word is registered into S.
  - If the new word equals S, the stable count increments, saturating at `STABLE_CYCLES`; otherwise the count clears to 0.
  - With `EN`=0, S and the count hold.
- **Acceptance:** in IDLE, when the count reaches `STABLE_CYCLES`-1 and S differs from the last accepted word (or nothing has been accepted since reset), S is captured into H.
  - All digits legal: go to CONV.
  - Any digit illegal: pulse `ERR` once (single pulse regardless of how many digits are bad), record H as last accepted, stay IDLE.
- **FSM states:** IDLE, CONV, DONE.
  - IDLE -> CONV on acceptance of a legal word.
  - CONV runs 4 steps, MSD first: `acc = acc*10 + d`, with `acc*10` computed as `(acc<<3)+(acc<<1)`.
  - CONV -> DONE after step 4. DONE -> IDLE after 1 cycle.
- **Arithmetic:** `acc` is 14 bits. Maximum is 999*10+9 = 9999, so no overflow is possible.
- **During CONV/DONE:** sampling continues and acceptance is deferred; a word stable on return to IDLE is accepted then.
- **Reset values:** `BCD`=0, `BIN`=0, `VALID`=0, `ERR`=0, `BUSY`=0, S=0, count=0, H=0, "accepted" flag cleared, `ERR_CNT`=0.
- **Reset mid-conversion:** aborts with no `VALID`.
- **Polarity change:** a change of `LED_type_ctl` changes S and forces re-stabilization.

## Timing
- Edge k: acceptance; H captured, `BUSY`=1.
- Edges k+1..k+4: the four accumulate steps.
- Edge k+4: `BIN`/`BCD` registered. `VALID`=1 for the cycle between edges k+4 and k+5.
- Edge k+5: back to IDLE, `BUSY`=0.
- `ERR` is asserted for the cycle after edge k; `BUSY` is not raised.
- Minimum input-change-to-`VALID` with `STABLE_CYCLES`=2: 6 enabled edges.
- `EN` gates sampling only; a started conversion always completes.

## Configuration
- `SEG7_READER_ERRCNT_EN` defined:
  - `ERR_CNT` is a saturating counter of `ERR` pulses, width `ERR_CNT_W`.
  - Cleared only by `RST`; holds at all-ones.
- `SEG7_READER_ERRCNT_EN` undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package `seg7_pkg`:
  - SEG_0..SEG_9 constants.
  - NUM_DIGITS=4.
  - FSM state typedef (IDLE/CONV/DONE).
- Sub-module `seg7_digit_decode`: combinational 7-bit -> {legal, 4-bit BCD}, instantiated 4 times on H.

## Test plan
- Reset released; active-high patterns for 0,0,0,0 held 3 cycles -> single `VALID`, `BIN`=0, `BCD`=16'h0000; no repeat while held.
- `LED4..LED1` = 1,2,3,4 (`LED_type_ctl`=0) held -> `VALID` at k+4, `BIN`=1234, `BCD`=16'h1234.
- `LED_type_ctl`=1 with inverted patterns for 9,9,9,9 -> `BIN`=9999, `BCD`=16'h9999.
- `LED2`=0000000 with other digits legal, held -> one `ERR` pulse, no `VALID`, `BIN` unchanged, `ERR_CNT`=1 with macro.
- Pattern toggling every cycle between 5 and 6 with `STABLE_CYCLES`=2 -> no `VALID`. Then hold 6,6,6,6 -> `BIN`=6666.
- `RST` asserted at edge k+2 of conversion of 4321 -> no `VALID`, all outputs 0; after release with the input still held -> `BIN`=4321.
